// File: rtl/mitchell_pipe.sv
// mitchell_pipe: 3-stage Mitchell log-domain approximate multiplier, valid/ready.
// Optional MITCHELL_PERF_EN adds perf_ops / perf_stall counters.
module mitchell_pipe #(
  parameter int A_BW   = 16,
  parameter int B_BW   = 16,
  parameter int FRAC_W = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [A_BW-1:0]      in_a,
  input  logic [B_BW-1:0]      in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [A_BW+B_BW-1:0] out_c
`ifdef MITCHELL_PERF_EN
  ,
  output logic [31:0]          perf_ops,
  output logic [31:0]          perf_stall
`endif
);
  localparam int N  = (A_BW > B_BW) ? A_BW : B_BW;
  localparam int CW = A_BW + B_BW;
  localparam int LW = $clog2(N);
  localparam int EW = $clog2(CW) + 1;
  localparam int PW = CW + FRAC_W + 1;

  logic            r_v1, r_v2, r_v3;
  logic [N-1:0]    r_ma1, r_mb1;
  logic            r_neg1, r_zero1;
  logic            r_neg2, r_zero2;
  logic [EW-1:0]   r_k2;
  logic [FRAC_W:0] r_s2;
  logic [CW-1:0]   r_c3;

  logic w_ld1, w_ld2, w_ld3;
  assign w_ld3    = !r_v3 || out_ready;
  assign w_ld2    = !r_v2 || w_ld3;
  assign w_ld1    = !r_v1 || w_ld2;
  assign in_ready = w_ld1;

  logic            w_sa, w_sb;
  logic [A_BW-1:0] w_ma;
  logic [B_BW-1:0] w_mb;
  assign w_sa = in_signed & in_a[A_BW-1];
  assign w_sb = in_signed & in_b[B_BW-1];
  assign w_ma = w_sa ? -in_a : in_a;
  assign w_mb = w_sb ? -in_b : in_b;

  function automatic logic [LW-1:0] lead_one(input logic [N-1:0] x);
    lead_one = '0;
    for (int i = 0; i < N; i++)
      if (x[i]) lead_one = LW'(i);
  endfunction

  logic [LW-1:0]     w_k1, w_k2;
  logic [N-1:0]      w_n1, w_n2;
  logic [FRAC_W-1:0] w_f1, w_f2;
  assign w_k1 = lead_one(r_ma1);
  assign w_k2 = lead_one(r_mb1);
  // normalise leading one to the msb; fraction is the bits just below it
  assign w_n1 = r_ma1 << (LW'(N - 1) - w_k1);
  assign w_n2 = r_mb1 << (LW'(N - 1) - w_k2);
  assign w_f1 = w_n1[N-2 -: FRAC_W];
  assign w_f2 = w_n2[N-2 -: FRAC_W];

  logic [FRAC_W:0] w_m;
  logic [EW-1:0]   w_e;
  logic [PW-1:0]   w_wide;
  logic [CW-1:0]   w_p;
  assign w_m    = r_s2[FRAC_W] ? r_s2 : {1'b1, r_s2[FRAC_W-1:0]};
  assign w_e    = r_k2 + EW'(r_s2[FRAC_W]);
  assign w_wide = PW'(w_m) << w_e;
  assign w_p    = w_wide[FRAC_W +: CW];

  logic w_unused;
  assign w_unused = ^{w_n1, w_n2, w_wide};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_c3 <= '0;
    end else begin
      if (w_ld1) r_v1 <= in_valid;
      if (w_ld2) r_v2 <= r_v1;
      if (w_ld3) r_v3 <= r_v2;
      if (w_ld3 && r_v2)
        r_c3 <= r_zero2 ? '0 : (r_neg2 ? -w_p : w_p);
    end
  end

  always_ff @(posedge clk) begin
    if (w_ld1 && in_valid) begin
      r_ma1   <= N'(w_ma);
      r_mb1   <= N'(w_mb);
      r_neg1  <= w_sa ^ w_sb;
      r_zero1 <= (w_ma == '0) || (w_mb == '0);
    end
    if (w_ld2 && r_v1) begin
      r_k2    <= EW'(w_k1) + EW'(w_k2);
      r_s2    <= {1'b0, w_f1} + {1'b0, w_f2};
      r_neg2  <= r_neg1;
      r_zero2 <= r_zero1;
    end
  end

  assign out_valid = r_v3;
  assign out_c     = r_c3;

`ifdef MITCHELL_PERF_EN
  logic [31:0] r_ops, r_stall;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ops   <= '0;
      r_stall <= '0;
    end else begin
      if (r_v3 && out_ready)  r_ops   <= r_ops + 32'd1;
      if (r_v3 && !out_ready) r_stall <= r_stall + 32'd1;
    end
  end
  assign perf_ops   = r_ops;
  assign perf_stall = r_stall;
`endif
endmodule
